// File: rtl/mic_peak_meter.sv
// Microphone peak meter: tracks the peak above MIDPOINT over a window of samples,
// converts it to a gated 0..31 level and maintains a decaying peak-hold level.
module mic_peak_meter #(
  parameter int WINDOW_SAMPLES = 4000,
  parameter int MIDPOINT       = 2048,
  parameter int NOISE_FLOOR    = 2,
  parameter int DECAY_WINDOWS  = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        sample_valid,
  input  logic [11:0] mic_in,
  output logic [4:0]  volume,
  output logic [4:0]  hold,
  output logic        volume_valid
);

  localparam int CW = $clog2(WINDOW_SAMPLES + 1);
  localparam int DW = $clog2(DECAY_WINDOWS + 1);
  localparam logic [11:0]   MID   = 12'(MIDPOINT);
  localparam logic [CW-1:0] LAST  = CW'(WINDOW_SAMPLES - 1);
  localparam logic [DW-1:0] DLAST = DW'(DECAY_WINDOWS - 1);
  localparam logic [31:0]   FLOOR = 32'(NOISE_FLOOR);

  typedef enum logic [1:0] {IDLE, ACCUM, UPDATE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dcnt;
  logic [11:0]   max_reg;
  logic [11:0]   peak;
  logic [4:0]    lvl_sat;
  logic [4:0]    lvl;
  logic [11:0]   first_max;

  // The compare guards the subtraction, and saturating the 6-bit shifted peak
  // keeps the level bounded whatever MIDPOINT is.
  always_comb begin
    peak      = (max_reg > MID) ? (max_reg - MID) : 12'd0;
    lvl_sat   = (peak[11:6] > 6'd31) ? 5'd31 : peak[10:6];
    lvl       = ({27'd0, lvl_sat} < FLOOR) ? 5'd0 : lvl_sat;
    first_max = (mic_in > MID) ? mic_in : MID;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      dcnt         <= '0;
      max_reg      <= MID;
      volume       <= 5'd0;
      hold         <= 5'd0;
      volume_valid <= 1'b0;
    end else begin
      volume_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            state   <= ACCUM;
            cnt     <= '0;
            max_reg <= MID;
          end
        end
        ACCUM: begin
          // Dropping en discards the partial window; re-entry via IDLE clears it.
          if (!en) begin
            state <= IDLE;
          end else if (sample_valid) begin
            if (mic_in > max_reg) max_reg <= mic_in;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= UPDATE;
          end
        end
        UPDATE: begin
          volume       <= lvl;
          volume_valid <= 1'b1;
          if (lvl >= hold) begin
            hold <= lvl;
            dcnt <= '0;
          end else if (dcnt == DLAST) begin
            hold <= hold - 1'b1;
            dcnt <= '0;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
          // A sample arriving now opens the next window rather than being lost.
          if (sample_valid) begin
            max_reg <= first_max;
            cnt     <= CW'(1);
          end else begin
            max_reg <= MID;
            cnt     <= '0;
          end
          state <= en ? ACCUM : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
